fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 30 +++
 rtl/if_id_reg.sv | 28 ++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared parameters, encodings and helpers for the fetch unit
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef enum logic [3:0] {
    ALUC_ADD  = 4'd0,
    ALUC_SUB  = 4'd1,
    ALUC_AND  = 4'd2,
    ALUC_OR   = 4'd3,
    ALUC_XOR  = 4'd4,
    ALUC_SLL  = 4'd5,
    ALUC_SRL  = 4'd6,
    ALUC_SRA  = 4'd7,
    ALUC_SLT  = 4'd8,
    ALUC_SLTU = 4'd9
  } aluc_e;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold and bubble insertion
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] inst,
  input  logic [31:0] pc4,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      id_inst  <= NOP;
      id_pc4   <= '0;
      id_valid <= 1'b0;
    end else if (load) begin
      id_inst  <= inst;
      id_pc4   <= pc4;
      id_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with stall buffering and redirect handling
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch,
  input  logic        cancel_next,
  input  logic [31:0] target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  fetch_state_e state_q;
  logic [31:0]  addr_q;
  logic [31:0]  buf_inst;
  logic [31:0]  buf_addr;
  logic [31:0]  redirect_q;
  logic         out_q;
  logic         stale_q;
  logic         squash;
  logic         ifid_load;
  logic         ifid_bubble;
  logic [31:0]  ifid_inst;
  logic [31:0]  ifid_pc4;

  assign imem_req  = !rst && (state_q != HOLD);
  assign imem_addr = addr_q;
  assign squash    = branch | cancel_next;

  // IF/ID only moves when ID accepts; a redirect always forces a bubble.
  always_comb begin
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_inst   = imem_rdata;
    ifid_pc4    = pc_plus4(addr_q);
    if (!stall || branch) begin
      case (state_q)
        FETCH: begin
          if (imem_ack && !squash && !stale_q) ifid_load = 1'b1;
          else ifid_bubble = 1'b1;
        end
        HOLD: begin
          if (!squash) begin
            ifid_load = 1'b1;
            ifid_inst = buf_inst;
            ifid_pc4  = pc_plus4(buf_addr);
          end else begin
            ifid_bubble = 1'b1;
          end
        end
        default: ifid_bubble = 1'b1;
      endcase
    end
  end

  // stale_q marks a request that was in flight when reset hit; its ack is swallowed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      addr_q     <= RESET_PC;
      buf_inst   <= NOP;
      buf_addr   <= '0;
      redirect_q <= '0;
      out_q      <= 1'b0;
      stale_q    <= (stale_q | out_q) & ~imem_ack;
    end else begin
      out_q <= imem_req & ~imem_ack;
      case (state_q)
        FETCH: begin
          if (branch) begin
            stale_q <= 1'b0;
            if (imem_ack) begin
              addr_q <= target;
            end else begin
              redirect_q <= target;
              state_q    <= DROP;
            end
          end else if (stale_q) begin
            if (imem_ack) stale_q <= 1'b0;
          end else if (imem_ack) begin
            if (stall) begin
              buf_inst <= imem_rdata;
              buf_addr <= addr_q;
              state_q  <= HOLD;
            end else begin
              addr_q <= pc_plus4(addr_q);
            end
          end
        end
        HOLD: begin
          if (branch) begin
            addr_q  <= target;
            state_q <= FETCH;
          end else if (!stall) begin
            addr_q  <= pc_plus4(buf_addr);
            state_q <= FETCH;
          end
        end
        default: begin
          if (imem_ack) begin
            addr_q  <= branch ? target : redirect_q;
            state_q <= FETCH;
          end else if (branch) begin
            redirect_q <= target;
          end
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load),
    .bubble   (ifid_bubble),
    .inst     (ifid_inst),
    .pc4      (ifid_pc4),
    .id_inst  (id_inst),
    .id_pc4   (id_pc4),
    .id_valid (id_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch;
  logic        cancel_next;
  logic [31:0] target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  logic        id_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .branch      (branch),
    .cancel_next (cancel_next),
    .target      (target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .id_inst     (id_inst),
    .id_pc4      (id_pc4),
    .id_valid    (id_valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ 32'h0F0F_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic a, input logic [31:0] d, input logic s,
                        input logic b, input logic [31:0] t);
    imem_ack    = a;
    imem_rdata  = d;
    stall       = s;
    branch      = b;
    cancel_next = b;
    target      = t;
  endtask

  logic [31:0] exp_pc;
  logic [31:0] pend_addr;
  logic [31:0] tgt;
  logic        pend;
  logic        s;
  logic        b;
  int          wait_cnt;
  int          consumed;

  initial begin
    rst = 1'b1;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    tick();
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_addr",  imem_addr,     32'h0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_inst",  id_inst,       32'h0);
    chk("rst_pc4",   id_pc4,        32'h0);

    // zero-wait stream from reset
    rst = 1'b0;
    #1;
    chk("rel_req",  32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr,     32'h0);
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, mem_word(32'(4 * i)), 1'b0, 1'b0, 32'h0);
      tick();
      chk("seq_valid", 32'(id_valid), 32'd1);
      chk("seq_pc4",   id_pc4,        32'(4 * (i + 1)));
      chk("seq_inst",  id_inst,       mem_word(32'(4 * i)));
      chk("seq_addr",  imem_addr,     32'(4 * (i + 1)));
    end

    // stall coincident with ack at 0x10
    set_in(1'b1, mem_word(32'h10), 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_req",   32'(imem_req), 32'd0);
      chk("hold_pc4",   id_pc4,        32'h10);
      chk("hold_inst",  id_inst,       mem_word(32'hC));
      chk("hold_valid", 32'(id_valid), 32'd1);
      set_in(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    end
    set_in(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    tick();
    chk("rel_pc4",   id_pc4,        32'h14);
    chk("rel_inst",  id_inst,       mem_word(32'h10));
    chk("rel_valid", 32'(id_valid), 32'd1);
    chk("rel_next",  imem_addr,     32'h14);
    chk("rel_req1",  32'(imem_req), 32'd1);

    // branch in the same cycle as ack
    set_in(1'b1, mem_word(32'h14), 1'b0, 1'b1, 32'h200);
    tick();
    chk("bra_addr",  imem_addr,     32'h200);
    chk("bra_valid", 32'(id_valid), 32'd0);
    chk("bra_inst",  id_inst,       32'h0);

    // latency-3 fetch at 0x20 redirected to 0x100
    set_in(1'b1, mem_word(32'h200), 1'b0, 1'b0, 32'h0);
    tick();
    chk("b200_pc4", id_pc4, 32'h204);
    set_in(1'b1, mem_word(32'h204), 1'b0, 1'b1, 32'h20);
    tick();
    chk("to20_addr", imem_addr, 32'h20);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
    tick();
    chk("drop_req",   32'(imem_req), 32'd1);
    chk("drop_addr",  imem_addr,     32'h20);
    chk("drop_valid", 32'(id_valid), 32'd0);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("drop_addr2",  imem_addr,     32'h20);
    chk("drop_valid2", 32'(id_valid), 32'd0);
    set_in(1'b1, mem_word(32'h20), 1'b0, 1'b0, 32'h0);
    tick();
    chk("drop_redir", imem_addr,     32'h100);
    chk("drop_valid3", 32'(id_valid), 32'd0);
    chk("drop_req2",  32'(imem_req), 32'd1);
    set_in(1'b1, mem_word(32'h100), 1'b0, 1'b0, 32'h0);
    tick();
    chk("t100_valid", 32'(id_valid), 32'd1);
    chk("t100_pc4",   id_pc4,        32'h104);
    chk("t100_inst",  id_inst,       mem_word(32'h100));

    // wrap at the top of the address space
    set_in(1'b1, mem_word(32'h104), 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    set_in(1'b1, mem_word(32'hFFFF_FFFC), 1'b0, 1'b0, 32'h0);
    tick();
    chk("wrap_pc4",   id_pc4,        32'h0);
    chk("wrap_valid", 32'(id_valid), 32'd1);
    chk("wrap_inst",  id_inst,       mem_word(32'hFFFF_FFFC));
    chk("wrap_addr",  imem_addr,     32'h0);

    // reset with a request to 0x40 in flight, stale ack after release
    set_in(1'b1, mem_word(32'h0), 1'b0, 1'b1, 32'h40);
    tick();
    chk("to40_addr", imem_addr, 32'h40);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("rst2_req",   32'(imem_req), 32'd0);
    chk("rst2_valid", 32'(id_valid), 32'd0);
    rst = 1'b0;
    set_in(1'b1, mem_word(32'h40), 1'b0, 1'b0, 32'h0);
    tick();
    chk("stale_valid", 32'(id_valid), 32'd0);
    chk("stale_addr",  imem_addr,     32'h0);
    chk("stale_req",   32'(imem_req), 32'd1);
    set_in(1'b1, mem_word(32'h0), 1'b0, 1'b0, 32'h0);
    tick();
    chk("first_valid", 32'(id_valid), 32'd1);
    chk("first_inst",  id_inst,       mem_word(32'h0));
    chk("first_pc4",   id_pc4,        32'h4);

    // randomized run against a program-order model with redirects
    rst = 1'b1;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    exp_pc   = 32'h0;
    pend     = 1'b0;
    wait_cnt = 0;
    consumed = 0;
    pend_addr = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      if (id_valid) begin
        chk("rnd_pc4",  id_pc4,  exp_pc + 32'd4);
        chk("rnd_inst", id_inst, mem_word(exp_pc));
      end else begin
        chk("rnd_nop", id_inst, 32'h0);
      end
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if (imem_req) begin
        if (!pend) begin
          pend      = 1'b1;
          pend_addr = imem_addr;
          wait_cnt  = $urandom_range(0, 3);
        end else begin
          chk("rnd_addr_stable", imem_addr, pend_addr);
        end
        if (wait_cnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(pend_addr);
          pend       = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
      s   = ($urandom % 4) == 0;
      b   = id_valid && !s && (($urandom % 5) == 0);
      tgt = (($urandom % 8) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 255)) << 2);
      stall       = s;
      branch      = b;
      cancel_next = b;
      target      = tgt;
      if (id_valid && !s) begin
        consumed++;
        exp_pc = b ? tgt : exp_pc + 32'd4;
      end
      tick();
    end
    chk("rnd_progress", 32'(consumed > 200), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
